// File: rtl/output_serializer_if.sv
// Bus bundle for output_serializer: frame/load inputs, result words and the
// serial outputs with their status flags.
interface output_serializer_if #(
   parameter int WIDTH = 40
);
   logic             Frame;
   logic             Load;
   logic [WIDTH-1:0] DataL;
   logic [WIDTH-1:0] DataR;
   logic             OutputL;
   logic             OutputR;
   logic             OutReady;
   logic             Busy;

   modport master (
      output Frame, Load, DataL, DataR,
      input  OutputL, OutputR, OutReady, Busy
   );

   modport slave (
      input  Frame, Load, DataL, DataR,
      output OutputL, OutputR, OutReady, Busy
   );
endinterface

// File: rtl/output_serializer.sv
// Stereo result serializer: a pending word is shifted out MSB first for WIDTH
// cycles per synchronised Frame edge. Optional OVERRUN_DET_EN adds a sticky Overrun flag.
module output_serializer #(
   parameter int WIDTH = 40
) (
   input  logic               Sclk,
   input  logic               Reset_n,
`ifdef OVERRUN_DET_EN
   output logic               Overrun,
`endif
   output_serializer_if.slave bus
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic             r_s1;
   logic             r_s2;
   logic             r_s3;
   logic             w_frame_pulse;
   logic [WIDTH-1:0] r_pend_l;
   logic [WIDTH-1:0] r_pend_r;
   logic [WIDTH-1:0] w_pend_l_next;
   logic [WIDTH-1:0] w_pend_r_next;
   logic             r_pend_valid;
   logic             w_pend_valid_next;
   logic [WIDTH-1:0] r_sh_l;
   logic [WIDTH-1:0] r_sh_r;
   logic [WIDTH-1:0] w_sh_l_next;
   logic [WIDTH-1:0] w_sh_r_next;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_next;
   logic             w_transfer;
   logic             r_out_ready;
   logic             r_busy;

   assign w_frame_pulse = r_s2 & ~r_s3;

   // Frame crosses from the Dclk domain: two sync flops plus one for edge detect.
   always_ff @(posedge Sclk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= bus.Frame;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   // Next-state and shift datapath; shift registers are left at zero outside SHIFT.
   always_comb begin
      w_next_state = r_state;
      w_transfer   = 1'b0;
      w_sh_l_next  = r_sh_l;
      w_sh_r_next  = r_sh_r;
      w_cnt_next   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (w_frame_pulse && r_pend_valid) begin
               w_next_state = ST_SHIFT;
               w_transfer   = 1'b1;
               w_sh_l_next  = r_pend_l;
               w_sh_r_next  = r_pend_r;
               w_cnt_next   = CNT_W'(WIDTH - 1);
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (r_cnt == {CNT_W{1'b0}}) begin
               w_next_state = ST_IDLE;
               w_sh_l_next  = {WIDTH{1'b0}};
               w_sh_r_next  = {WIDTH{1'b0}};
            end else begin
               w_sh_l_next  = {r_sh_l[WIDTH-2:0], 1'b0};
               w_sh_r_next  = {r_sh_r[WIDTH-2:0], 1'b0};
               w_cnt_next   = r_cnt - CNT_W'(1'b1);
            end
         end
         default: begin
            w_next_state = ST_IDLE;
            w_sh_l_next  = {WIDTH{1'b0}};
            w_sh_r_next  = {WIDTH{1'b0}};
            w_cnt_next   = {CNT_W{1'b0}};
         end
      endcase
   end

   // A Load always wins the pending buffer; the transfer reads the old contents.
   always_comb begin
      w_pend_l_next     = r_pend_l;
      w_pend_r_next     = r_pend_r;
      w_pend_valid_next = r_pend_valid;
      if (bus.Load) begin
         w_pend_l_next     = bus.DataL;
         w_pend_r_next     = bus.DataR;
         w_pend_valid_next = 1'b1;
      end else if (w_transfer) begin
         w_pend_valid_next = 1'b0;
      end else begin
         w_pend_valid_next = r_pend_valid;
      end
   end

   // State, datapath and registered status outputs.
   always_ff @(posedge Sclk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state      <= ST_IDLE;
         r_pend_l     <= {WIDTH{1'b0}};
         r_pend_r     <= {WIDTH{1'b0}};
         r_pend_valid <= 1'b0;
         r_sh_l       <= {WIDTH{1'b0}};
         r_sh_r       <= {WIDTH{1'b0}};
         r_cnt        <= {CNT_W{1'b0}};
         r_out_ready  <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_state      <= w_next_state;
         r_pend_l     <= w_pend_l_next;
         r_pend_r     <= w_pend_r_next;
         r_pend_valid <= w_pend_valid_next;
         r_sh_l       <= w_sh_l_next;
         r_sh_r       <= w_sh_r_next;
         r_cnt        <= w_cnt_next;
         r_out_ready  <= (w_next_state == ST_SHIFT);
         r_busy       <= (w_next_state == ST_SHIFT) | w_pend_valid_next;
      end
   end

`ifdef OVERRUN_DET_EN
   logic r_overrun;

   // Sticky flag: a pending word was replaced before it could be sent.
   always_ff @(posedge Sclk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_overrun <= 1'b0;
      end else if (bus.Load && r_pend_valid && !w_transfer) begin
         r_overrun <= 1'b1;
      end else begin
         r_overrun <= r_overrun;
      end
   end

   assign Overrun = r_overrun;
`endif

   assign bus.OutputL  = r_sh_l[WIDTH-1];
   assign bus.OutputR  = r_sh_r[WIDTH-1];
   assign bus.OutReady = r_out_ready;
   assign bus.Busy     = r_busy;

endmodule
